// File: rtl/shreg_ser_ctrl_if.sv
// Signal bundle between the PISO sequencer, its 4-bit shift register and the
// upstream/downstream handshakes. master = sequencer view, slave = environment view.
interface shreg_ser_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_in;
  logic             sr_shr;
  logic             ser_valid;
  logic             ser_bit;
  logic             ser_last;
  logic             ser_ready;
  logic             busy;

  modport master (
    input  in_valid, in_data, sr_q, ser_ready,
    output in_ready, sr_in, sr_shr, ser_valid, ser_bit, ser_last, busy
  );

  modport slave (
    output in_valid, in_data, sr_q, ser_ready,
    input  in_ready, sr_in, sr_shr, ser_valid, ser_bit, ser_last, busy
  );
endinterface

// File: rtl/shreg_ser_ctrl.sv
// Sequencer that turns an enable-less load/shift register into an LSB-first
// parallel-in serial-out serializer with valid/ready on both sides.
module shreg_ser_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  shreg_ser_ctrl_if.master  bus
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last        = (state_q == SEND) && (cnt_q == CNT_W'(WIDTH - 1));
  assign bus.ser_bit = bus.sr_q[0];

  // The register has no enable: every non-shift cycle must reload something,
  // so "hold" means feeding sr_q straight back onto sr_in.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.in_ready  = 1'b0;
    bus.sr_shr    = 1'b0;
    bus.sr_in     = bus.sr_q;
    bus.ser_valid = 1'b0;
    bus.ser_last  = 1'b0;
    bus.busy      = 1'b0;
    if (rst) begin
      bus.sr_in = '0;
    end else begin
      case (state_q)
        IDLE: begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            bus.sr_in = bus.in_data;
            cnt_d     = '0;
            state_d   = SEND;
          end
        end
        SEND: begin
          bus.busy      = 1'b1;
          bus.ser_valid = 1'b1;
          bus.ser_last  = last;
          if (bus.ser_ready) begin
            if (!last) begin
              bus.sr_shr = 1'b1;
              cnt_d      = cnt_q + CNT_W'(1);
            end else begin
              // last bit leaving: accept the next word in the same cycle
              bus.in_ready = 1'b1;
              if (bus.in_valid) begin
                bus.sr_in = bus.in_data;
                cnt_d     = '0;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shreg_ser_ctrl.sv
// Bench for shreg_ser_ctrl: behavioural 4-bit MSB-replicating shift register in
// the feedback path, and a bit-queue reference model of the serial stream.
module tb_shreg_ser_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shreg_ser_ctrl_if #(.WIDTH(W)) ifc ();

  shreg_ser_ctrl #(.WIDTH(W), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always @(posedge clk)
    ifc.sr_q <= ifc.sr_shr ? {ifc.sr_q[W-1], ifc.sr_q[W-1:1]} : ifc.sr_in;

  int   n_asrt = 0;
  int   n_fail = 0;
  bit   q[$];
  logic [7:0] col;
  int   ncol;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic iv, input logic [W-1:0] d, input logic sr);
    logic ev, eir;
    rst           = r;
    ifc.in_valid  = iv;
    ifc.in_data   = d;
    ifc.ser_ready = sr;
    @(negedge clk);
    ev  = !r && (q.size() > 0);
    eir = !r && ((q.size() == 0) || (q.size() == 1 && sr));
    chk("in_ready",  {7'd0, ifc.in_ready},  {7'd0, eir});
    chk("ser_valid", {7'd0, ifc.ser_valid}, {7'd0, ev});
    chk("busy",      {7'd0, ifc.busy},      {7'd0, ev});
    if (ev) begin
      chk("ser_bit",  {7'd0, ifc.ser_bit},  {7'd0, q[0]});
      chk("ser_last", {7'd0, ifc.ser_last}, {7'd0, q.size() == 1});
      if (sr && ncol < 8) begin
        col[ncol] = ifc.ser_bit;
        ncol++;
      end
    end else begin
      chk("ser_last_idle", {7'd0, ifc.ser_last}, 8'd0);
    end
    if (r) begin
      chk("rst_sr_in",  {4'd0, ifc.sr_in}, 8'd0);
      chk("rst_sr_shr", {7'd0, ifc.sr_shr}, 8'd0);
    end
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (ev && sr) void'(q.pop_front());
      if (eir && iv) for (int i = 0; i < W; i++) q.push_back(d[i]);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.ser_ready = 1'b0;
    col = '0; ncol = 0;
    cyc(1, 0, 4'h0, 0);
    cyc(1, 1, 4'h7, 1);
    chk("reset_sr_q", {4'd0, ifc.sr_q}, 8'h00);

    // 1: 1011 streamed with ready held high
    col = '0; ncol = 0;
    cyc(0, 1, 4'b1011, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'h0, 1);
    chk("t1_bits", {4'd0, col[3:0]}, 8'h0B);
    chk("t1_count", 8'(ncol), 8'd4);

    // 2: 0110 with a 3-cycle stall on bit1
    col = '0; ncol = 0;
    cyc(0, 1, 4'b0110, 1);
    cyc(0, 0, 4'h0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 4'hF, 0);
      chk("t2_hold_sr_q", {4'd0, ifc.sr_q}, 8'h03);
    end
    cyc(0, 0, 4'h0, 1);
    cyc(0, 0, 4'h0, 1);
    cyc(0, 0, 4'h0, 1);
    chk("t2_bits", {4'd0, col[3:0]}, 8'h06);

    // 3: back-to-back A then 5
    col = '0; ncol = 0;
    cyc(0, 1, 4'hA, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'h5, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'h3, 1);
    chk("t3_bits", col, 8'h5A);
    chk("t3_count", 8'(ncol), 8'd8);

    // 4: reset during bit2 of F, then word 1
    cyc(0, 1, 4'hF, 1);
    cyc(0, 0, 4'h0, 1);
    cyc(0, 0, 4'h0, 1);
    cyc(1, 0, 4'h0, 1);
    chk("t4_sr_q_cleared", {4'd0, ifc.sr_q}, 8'h00);
    col = '0; ncol = 0;
    cyc(0, 1, 4'h1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'h0, 1);
    chk("t4_bits", {4'd0, col[3:0]}, 8'h01);
    chk("t4_count", 8'(ncol), 8'd4);

    // 5: 9 completes, then idle; register holds the replicated MSB pattern
    cyc(0, 1, 4'h9, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 4'h0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 4'(i), $urandom_range(0, 1) == 1);
      chk("t5_idle_sr_q", {4'd0, ifc.sr_q}, 8'h0F);
    end

    // random traffic against the reference model
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
          4'($urandom), $urandom_range(0, 3) != 0);
    cyc(1, 0, 4'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
